// File: rtl/bram_debug_sequencer.sv
// Sequencer for the RV32Core debug BRAM port. It loads a word stream into BRAM,
// pulses the core reset, runs the core for a set number of cycles, then freezes it and streams BRAM out.
module bram_debug_sequencer #(
    parameter int RST_CYCLES = 5,
    parameter int LEN_W      = 13
) (
    input  logic             CPU_CLK,
    input  logic             CPU_RST,
    input  logic             start,
    input  logic [LEN_W-1:0] load_len,
    input  logic [31:0]      run_cycles,
    input  logic [LEN_W-1:0] dump_len,
    input  logic [31:0]      load_data,
    input  logic             load_valid,
    output logic             load_ready,
    output logic [31:0]      dump_data,
    output logic [31:0]      dump_addr,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [31:0]      dbg_a2,
    output logic [31:0]      dbg_wd2,
    output logic [3:0]       dbg_we2,
    input  logic [31:0]      dbg_rd2,
    output logic             core_rst,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_RSTC   = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_DUMP_A = 3'd4;
    localparam logic [2:0] S_DUMP_W = 3'd5;
    localparam logic [2:0] S_DUMP_O = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(4096);

    logic [2:0]       state_q, state_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] load_len_q, load_len_d;
    logic [LEN_W-1:0] dump_len_q, dump_len_d;
    logic [31:0]      run_q, run_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [31:0]      dbg_a2_q, dbg_a2_d;
    logic [31:0]      dbg_wd2_q, dbg_wd2_d;
    logic [3:0]       dbg_we2_q, dbg_we2_d;
    logic             load_ready_q, load_ready_d;
    logic [31:0]      dump_data_q, dump_data_d;
    logic [31:0]      dump_addr_q, dump_addr_d;
    logic             dump_valid_q, dump_valid_d;
    logic             core_rst_q, core_rst_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [31:0]      idx_addr;
    logic [31:0]      run_lim;
    logic [LEN_W-1:0] load_len_c;
    logic [LEN_W-1:0] dump_len_c;

    assign idx_addr   = 32'(idx_q) << 2;
    assign run_lim    = (run_q == 32'd0) ? 32'd1 : run_q;
    assign load_len_c = (load_len > MAX_LEN) ? MAX_LEN : load_len;
    assign dump_len_c = (dump_len > MAX_LEN) ? MAX_LEN : dump_len;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        load_len_d   = load_len_q;
        dump_len_d   = dump_len_q;
        run_d        = run_q;
        cnt_d        = cnt_q;
        dbg_a2_d     = dbg_a2_q;
        dbg_wd2_d    = dbg_wd2_q;
        dbg_we2_d    = 4'h0;
        load_ready_d = load_ready_q;
        dump_data_d  = dump_data_q;
        dump_addr_d  = dump_addr_q;
        dump_valid_d = dump_valid_q;
        core_rst_d   = core_rst_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    load_len_d = load_len_c;
                    dump_len_d = dump_len_c;
                    run_d      = run_cycles;
                    idx_d      = '0;
                    cnt_d      = 32'd0;
                    if (load_len_c != '0) begin
                        state_d      = S_LOAD;
                        load_ready_d = 1'b1;
                    end else begin
                        state_d = S_RSTC;
                    end
                end
            end
            S_LOAD: begin
                if (load_valid && load_ready_q) begin
                    dbg_a2_d  = idx_addr;
                    dbg_wd2_d = load_data;
                    dbg_we2_d = 4'hF;
                    idx_d     = idx_q + 1'b1;
                    if (idx_q == load_len_q - 1'b1) begin
                        state_d      = S_RSTC;
                        load_ready_d = 1'b0;
                        cnt_d        = 32'd0;
                    end
                end
            end
            S_RSTC: begin
                if (cnt_q == 32'(RST_CYCLES - 1)) begin
                    state_d    = S_RUN;
                    core_rst_d = 1'b0;
                    cnt_d      = 32'd0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_RUN: begin
                // Re-asserting core_rst on the same edge that leaves RUN freezes the core.
                if (cnt_q == run_lim - 32'd1) begin
                    state_d    = S_DUMP_A;
                    core_rst_d = 1'b1;
                    idx_d      = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_DUMP_A: begin
                if (dump_len_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    dbg_a2_d = idx_addr;
                    state_d  = S_DUMP_W;
                end
            end
            S_DUMP_W: begin
                dump_data_d  = dbg_rd2;
                dump_addr_d  = idx_addr;
                dump_valid_d = 1'b1;
                state_d      = S_DUMP_O;
            end
            S_DUMP_O: begin
                if (dump_ready) begin
                    dump_valid_d = 1'b0;
                    idx_d        = idx_q + 1'b1;
                    state_d      = (idx_q == dump_len_q - 1'b1) ? S_DONE : S_DUMP_A;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge CPU_CLK) begin
        if (CPU_RST) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            load_len_q   <= '0;
            dump_len_q   <= '0;
            run_q        <= 32'd0;
            cnt_q        <= 32'd0;
            dbg_a2_q     <= 32'd0;
            dbg_wd2_q    <= 32'd0;
            dbg_we2_q    <= 4'h0;
            load_ready_q <= 1'b0;
            dump_data_q  <= 32'd0;
            dump_addr_q  <= 32'd0;
            dump_valid_q <= 1'b0;
            core_rst_q   <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            load_len_q   <= load_len_d;
            dump_len_q   <= dump_len_d;
            run_q        <= run_d;
            cnt_q        <= cnt_d;
            dbg_a2_q     <= dbg_a2_d;
            dbg_wd2_q    <= dbg_wd2_d;
            dbg_we2_q    <= dbg_we2_d;
            load_ready_q <= load_ready_d;
            dump_data_q  <= dump_data_d;
            dump_addr_q  <= dump_addr_d;
            dump_valid_q <= dump_valid_d;
            core_rst_q   <= core_rst_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign load_ready = load_ready_q;
    assign dump_data  = dump_data_q;
    assign dump_addr  = dump_addr_q;
    assign dump_valid = dump_valid_q;
    assign dbg_a2     = dbg_a2_q;
    assign dbg_wd2    = dbg_wd2_q;
    assign dbg_we2    = dbg_we2_q;
    assign core_rst   = core_rst_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
